// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data RAM serving Memory-stage loads/stores
// with a fixed wait-state latency, a completion pulse and an address error flag.
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReqM,
    input  logic        MemWriteM,
    input  logic [31:0] AddrM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        MemReadyM,
    output logic        MemErrM,
    output logic        StallMem
);

    localparam int         AW      = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] read_data_q, read_data_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic          acc_wr;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic          acc_legal;
    logic [AW-1:0] acc_word;
    logic          complete;
    logic          mem_we;

    // Access being completed: the live inputs when a zero-wait request
    // completes straight from IDLE, otherwise the latched request.
    always_comb begin
        if (state_q == IDLE) begin
            acc_wr    = MemWriteM;
            acc_addr  = AddrM;
            acc_wdata = WriteDataM;
        end else begin
            acc_wr    = wr_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
        acc_word  = acc_addr[AW+1:2];
        acc_legal = (acc_addr[1:0] == 2'b00) &&
                    (acc_addr[31:2] < 30'(DEPTH_WORDS));
    end

    // Next-state, request latching and completion side effects.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        read_data_d = read_data_q;
        err_d       = err_q;
        complete    = 1'b0;

        case (state_q)
            IDLE: begin
                if (MemReqM) begin
                    wr_d    = MemWriteM;
                    addr_d  = AddrM;
                    wdata_d = WriteDataM;
                    cnt_d   = WAIT_LD;
                    if (WAIT_LD == 4'd0) begin
                        state_d  = DONE;
                        complete = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d  = DONE;
                    complete = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (complete) begin
            err_d = ~acc_legal;
            if (!acc_legal) begin
                read_data_d = '0;
            end else if (!acc_wr) begin
                read_data_d = mem_q[acc_word];
            end
        end

        mem_we = complete & acc_wr & acc_legal & ~reset;
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            read_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            read_data_q <= read_data_d;
            err_q       <= err_d;
        end
    end

    // RAM array; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[acc_word] <= acc_wdata;
        end
    end

    assign ReadDataM = read_data_q;
    assign MemReadyM = (state_q == DONE);
    assign MemErrM   = (state_q == DONE) & err_q;
    assign StallMem  = ~reset & (((state_q == IDLE) & MemReqM) | (state_q == BUSY));

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states) driven by
// directed and random accesses, checked against an array-based memory model.
module tb_dmem_responder;

    localparam int DEPTH = 64;

    logic        clk;
    logic        rst   [2];
    logic        req   [2];
    logic        wr    [2];
    logic [31:0] addr  [2];
    logic [31:0] wd    [2];
    logic [31:0] rd    [2];
    logic        ready [2];
    logic        err   [2];
    logic        stall [2];

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_mem [2][DEPTH];
    logic [31:0] last_rd   [2];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut_w2 (
        .clk(clk), .reset(rst[0]), .MemReqM(req[0]), .MemWriteM(wr[0]),
        .AddrM(addr[0]), .WriteDataM(wd[0]), .ReadDataM(rd[0]),
        .MemReadyM(ready[0]), .MemErrM(err[0]), .StallMem(stall[0])
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .reset(rst[1]), .MemReqM(req[1]), .MemWriteM(wr[1]),
        .AddrM(addr[1]), .WriteDataM(wd[1]), .ReadDataM(rd[1]),
        .MemReadyM(ready[1]), .MemErrM(err[1]), .StallMem(stall[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wait_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One complete access on instance d, checking stall/ready timing and data.
    task automatic access(input int d, input bit w, input logic [31:0] a, input logic [31:0] data);
        bit          legal;
        int          lat;
        int          idx;
        logic [31:0] exp_rd;
        legal  = (a[1:0] == 2'b00) && (a < 32'(4 * DEPTH));
        lat    = wait_of(d) + 1;
        idx    = int'(a >> 2) % DEPTH;
        exp_rd = last_rd[d];
        if (!legal)  exp_rd = '0;
        else if (!w) exp_rd = model_mem[d][idx];

        @(negedge clk);
        req[d] = 1'b1; wr[d] = w; addr[d] = a; wd[d] = data;
        #1;
        check("stall_on_request", {31'd0, stall[d]}, 32'd1);
        check("ready_idle", {31'd0, ready[d]}, 32'd0);
        @(posedge clk);
        #1;
        req[d] = 1'b0; wr[d] = $urandom_range(0, 1); addr[d] = $urandom; wd[d] = $urandom;
        for (int i = 1; i <= lat; i++) begin
            if (i > 1) begin
                @(posedge clk);
                #1;
            end
            if (i < lat) begin
                check("ready_busy", {31'd0, ready[d]}, 32'd0);
                check("stall_busy", {31'd0, stall[d]}, 32'd1);
            end else begin
                check("ready_done", {31'd0, ready[d]}, 32'd1);
                check("err_done", {31'd0, err[d]}, {31'd0, ~legal});
                check("stall_done", {31'd0, stall[d]}, 32'd0);
                check("rdata_done", rd[d], exp_rd);
            end
        end
        if (legal && w) model_mem[d][idx] = data;
        last_rd[d] = exp_rd;
        @(posedge clk);
        #1;
        check("ready_after", {31'd0, ready[d]}, 32'd0);
        check("rdata_hold", rd[d], exp_rd);
    endtask

    // Request held high across two loads; second accepted only after DONE.
    task automatic back_to_back(input int d, input logic [31:0] a1, input logic [31:0] a2);
        int          n;
        int          pos  [4];
        logic [31:0] dat  [4];
        int          wt;
        wt = wait_of(d);
        n  = 0;
        @(negedge clk);
        req[d] = 1'b1; wr[d] = 1'b0; addr[d] = a1;
        for (int c = 1; c <= 2 * wt + 3; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) addr[d] = a2;
            if (ready[d] === 1'b1) begin
                check("stall_in_done_with_req", {31'd0, stall[d]}, 32'd0);
                if (n < 4) begin
                    pos[n] = c;
                    dat[n] = rd[d];
                end
                n++;
            end
        end
        req[d] = 1'b0;
        check("b2b_pulse_count", 32'(n), 32'd2);
        if (n >= 2) begin
            check("b2b_first_pos", 32'(pos[0]), 32'(wt + 1));
            check("b2b_spacing", 32'(pos[1] - pos[0]), 32'(wt + 2));
            check("b2b_first_data", dat[0], model_mem[d][int'(a1 >> 2)]);
            check("b2b_second_data", dat[1], model_mem[d][int'(a2 >> 2)]);
        end
        last_rd[d] = model_mem[d][int'(a2 >> 2)];
        repeat (2) @(posedge clk);
        #1;
        check("b2b_idle_after", {31'd0, ready[d]}, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        bit          w;
        int          kind;

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wd[d] = '0;
            last_rd[d] = '0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("reset_rdata", rd[d], 32'd0);
            check("reset_ready", {31'd0, ready[d]}, 32'd0);
            check("reset_err", {31'd0, err[d]}, 32'd0);
            check("reset_stall", {31'd0, stall[d]}, 32'd0);
        end

        // Known RAM contents everywhere
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++)
                access(d, 1'b1, 32'(i * 4), $urandom);

        // Store then load
        access(0, 1'b1, 32'h10, 32'hDEADBEEF);
        access(0, 1'b0, 32'h10, 32'h0);
        access(1, 1'b1, 32'h0, 32'h12345678);
        access(1, 1'b0, 32'h0, 32'h0);

        // Illegal addresses, then a legal load is unaffected
        for (int d = 0; d < 2; d++) begin
            access(d, 1'b0, 32'h13, 32'h0);
            access(d, 1'b0, 32'h100, 32'h0);
            access(d, 1'b1, 32'h100, 32'hCAFEF00D);
            access(d, 1'b0, 32'h10, 32'h0);
        end

        // Reset during first BUSY cycle discards the store
        access(0, 1'b1, 32'h20, 32'h01020304);
        @(negedge clk);
        req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h20; wd[0] = 32'hAAAA5555;
        @(posedge clk);
        #1;
        req[0] = 1'b0;
        @(negedge clk);
        rst[0] = 1'b1;
        #1;
        check("stall_under_reset", {31'd0, stall[0]}, 32'd0);
        @(negedge clk);
        rst[0] = 1'b0;
        last_rd[0] = '0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("no_ready_after_abort", {31'd0, ready[0]}, 32'd0);
        end
        check("rdata_after_abort_reset", rd[0], 32'd0);
        access(0, 1'b0, 32'h20, 32'h0);

        // Reset together with a request in IDLE: request not taken
        for (int d = 0; d < 2; d++) begin
            @(negedge clk);
            rst[d] = 1'b1; req[d] = 1'b1; wr[d] = 1'b1; addr[d] = 32'h30; wd[d] = 32'h55AA55AA;
            @(negedge clk);
            rst[d] = 1'b0; req[d] = 1'b0;
            last_rd[d] = '0;
            for (int i = 0; i < 4; i++) begin
                @(posedge clk);
                #1;
                check("no_ready_reset_req", {31'd0, ready[d]}, 32'd0);
                check("no_stall_reset_req", {31'd0, stall[d]}, 32'd0);
            end
            access(d, 1'b0, 32'h30, 32'h0);
        end

        // Request held across two loads
        back_to_back(0, 32'h4, 32'h8);
        back_to_back(1, 32'h4, 32'h8);

        // Random mix of legal and illegal loads/stores
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 40; n++) begin
                kind = $urandom_range(0, 9);
                w    = 1'($urandom_range(0, 1));
                if (kind == 0)      a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
                else if (kind == 1) a = ($urandom | 32'h100) & 32'hFFFF_FFFC;
                else                a = 32'($urandom_range(0, DEPTH - 1) * 4);
                access(d, w, a, $urandom);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving load/store requests from the Memory stage of the pipelined ARM core.
- Holds a word-addressed RAM with a fixed, configurable wait-state latency.
- While a request is in service it drives a stall toward the hazard unit, so the pipeline holds until the access completes.
- Completion is signalled with a one-cycle ready pulse, plus an error flag for illegal addresses.

Parameters:
DEPTH_WORDS, 64, number of 32-bit words in the RAM; power of two, minimum 4.
WAIT_CYCLES, 2, wait states inserted between acceptance and completion; range 0..15.

Ports:
clk  input  1  single clock; all state changes on its rising edge.
reset  input  1  synchronous, active-high reset.
MemReqM  input  1  request valid from the Memory stage.
MemWriteM  input  1  1 = store, 0 = load; sampled with MemReqM.
AddrM  input  32  byte address (ALUResult of the Memory stage).
WriteDataM  input  32  store data.
ReadDataM  output  32  load data; registered.
MemReadyM  output  1  one-cycle completion pulse.
MemErrM  output  1  asserted together with MemReadyM when the access was illegal.
StallMem  output  1  stall request to the hazard unit.

Behaviour:
- Reset:
  - Sampled high at an edge: state goes to IDLE; counter and latched request clear.
  - ReadDataM=0, MemReadyM=0, MemErrM=0.
  - RAM contents are not altered by reset.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - When MemReqM=1 at an edge, latch MemWriteM, AddrM and WriteDataM, and load counter=WAIT_CYCLES.
  - Next state is BUSY if WAIT_CYCLES>0, otherwise DONE.
  - When MemReqM=0, stay in IDLE.
- BUSY:
  - Counter decrements each cycle.
  - When counter==1 at an edge, go to DONE.
  - BUSY therefore lasts exactly WAIT_CYCLES cycles.
  - MemReqM and its inputs are ignored while BUSY.
- Entering DONE (edge from BUSY, or from IDLE when WAIT_CYCLES=0):
  - Legal store: RAM[word] <= latched data.
  - Legal load: ReadDataM <= RAM[word].
  - Illegal access: no RAM write, ReadDataM <= 0.
- DONE:
  - Lasts exactly one cycle; MemReadyM=1, MemErrM=1 if the access was illegal.
  - Always returns to IDLE.
  - A MemReqM present during DONE is not accepted; it must still be asserted in IDLE to be taken.
- Latency: MemReadyM is high in the (WAIT_CYCLES+1)th cycle after the accepting edge.
- ReadDataM holds its value until the next load completion or error completion; store completions leave it unchanged.
- Addressing:
  - word = AddrM[log2(DEPTH_WORDS)+1:2].
  - The access is illegal if AddrM[1:0]!=0 or AddrM[31:2] >= DEPTH_WORDS.
- StallMem is combinational:
  - StallMem = (state==IDLE & MemReqM) | (state==BUSY).
  - It is 0 in DONE, so the pipeline advances in the completion cycle.
  - The reset term takes priority: StallMem=0 while reset=1.
- Reset mid-operation: if reset is asserted in BUSY, the pending store is discarded and no ready pulse is produced. If it is asserted in DONE, the RAM update has already occurred and is kept.
- Simultaneous reset and MemReqM in IDLE: reset wins and the request is not accepted.
- No other side effects: one outstanding access at most, no buffering, no byte enables (word accesses only).

Test Plan:
1. Reset with WAIT_CYCLES=2 -> all outputs 0 and StallMem=0 on the cycle after reset. Drive MemReqM=1 in IDLE -> StallMem=1 in the same cycle.
2. Store 0xDEADBEEF to 0x10, then load 0x10 (WAIT_CYCLES=2) -> StallMem high for 3 cycles per access; MemReadyM pulses in the 3rd cycle after acceptance; ReadDataM=0xDEADBEEF and MemErrM=0.
3. WAIT_CYCLES=0: load 0x0 after storing 0x12345678 -> MemReadyM in the cycle immediately after acceptance; StallMem high only in the accepting cycle; ReadDataM=0x12345678.
4. Load from 0x13 (misaligned) and from 0x100 (DEPTH_WORDS=64, out of range) -> MemReadyM=1 with MemErrM=1; ReadDataM=0; a following load of 0x10 is unchanged.
5. Store 0xAAAA5555 to 0x20, assert reset during the 1st BUSY cycle -> no MemReadyM. A later load of 0x20 returns the pre-store contents.
6. Hold MemReqM=1 continuously for two loads (0x4, 0x8) -> the second is accepted only in the IDLE cycle after DONE, giving two ready pulses WAIT_CYCLES+2 cycles apart with the correct data.
